stream_arbiter: RTL

STREAM_ARBITER -- requirements
Module: stream_arbiter

---
 rtl/stream_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/stream_arbiter.sv
// stream_arbiter: packet-locked round-robin arbiter feeding a single
// registered output stage. One bubble cycle per packet for arbitration;
// once locked, the granted source streams at full throughput.
module stream_arbiter #(
  parameter int N_SRC        = 2,
  parameter int S_KEEP_WIDTH = 3,
  parameter int T_DATA_WIDTH = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_SRC-1:0]                        s_valid_i,
  output logic [N_SRC-1:0]                        s_ready_o,
  input  logic [N_SRC-1:0]                        s_last_i,
  input  logic [N_SRC*S_KEEP_WIDTH-1:0]           s_keep_i,
  input  logic [N_SRC*S_KEEP_WIDTH*T_DATA_WIDTH-1:0] s_data_i,
  output logic                                    m_valid_o,
  input  logic                                    m_ready_i,
  output logic                                    m_last_o,
  output logic [S_KEEP_WIDTH-1:0]                 m_keep_o,
  output logic [S_KEEP_WIDTH*T_DATA_WIDTH-1:0]    m_data_o,
  output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] grant_o,
  output logic                                    busy_o,
  output logic [CNT_WIDTH-1:0]                    pkt_count_o
);

  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int DW = S_KEEP_WIDTH * T_DATA_WIDTH;

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t                  state_q;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           sel_d;
  logic                    found_d;
  logic                    m_valid_q;
  logic                    m_last_q;
  logic [S_KEEP_WIDTH-1:0] m_keep_q;
  logic [DW-1:0]           m_data_q;
  logic [CNT_WIDTH-1:0]    cnt_q;

  logic                    g_valid;
  logic                    g_last;
  logic [S_KEEP_WIDTH-1:0] g_keep;
  logic [DW-1:0]           g_data;
  logic                    out_free;
  logic                    accept;
  logic                    load;

  // Round-robin search for the first valid source after the last grant.
  always_comb begin : arb_c
    logic [GW-1:0] cand;
    int unsigned   idx;
    sel_d   = grant_q;
    found_d = 1'b0;
    cand    = '0;
    idx     = 0;
    for (int unsigned i = 1; i <= N_SRC; i++) begin
      idx  = (32'(grant_q) + i) % N_SRC;
      cand = GW'(idx);
      if (!found_d && s_valid_i[cand]) begin
        found_d = 1'b1;
        sel_d   = cand;
      end
    end
  end

  assign out_free = !m_valid_q || m_ready_i;

  // Select the granted source's beat and drive its ready while locked.
  always_comb begin
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_keep    = '0;
    g_data    = '0;
    s_ready_o = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (GW'(k) == grant_q) begin
        g_valid      = s_valid_i[k];
        g_last       = s_last_i[k];
        g_keep       = s_keep_i[k*S_KEEP_WIDTH +: S_KEEP_WIDTH];
        g_data       = s_data_i[k*DW +: DW];
        s_ready_o[k] = (state_q == LOCK) && out_free;
      end
    end
  end

  assign accept = (state_q == LOCK) && g_valid && out_free;
  // Empty non-final beats are consumed but never reach the output stage.
  assign load   = accept && (g_last || (|g_keep));

  // Arbitration FSM, output register and packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= GW'(N_SRC - 1);
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_keep_q  <= '0;
      m_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q <= sel_d;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (accept && g_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (load) begin
        m_valid_q <= 1'b1;
        m_last_q  <= g_last;
        m_keep_q  <= g_keep;
        m_data_q  <= g_data;
      end else if (m_ready_i) begin
        m_valid_q <= 1'b0;
      end

      if (m_valid_q && m_ready_i && m_last_q) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign m_valid_o   = m_valid_q;
  assign m_last_o    = m_last_q;
  assign m_keep_o    = m_keep_q;
  assign m_data_o    = m_data_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == LOCK);
  assign pkt_count_o = cnt_q;

endmodule
